dcache_req_arbiter: RTL and testbench

- Sequential arbiter that shares the single data-cache controller request port between the PTW, load-unit and store-unit ports.
- Port indices match `dcache_pkg::request_port_select_t`: 0 = PTW, 1 = load, 2 = store.
- Accepts one request at a time and latches the winner's address, size, byte-enable and write data.
- Holds the downstream request until the cache grants it, then routes the load response back to the owning port.

---
 rtl/dcache_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dcache_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: shares the single data-cache controller request port
// between the PTW (0), load unit (1) and store unit (2). One transaction is
// outstanding at a time; the winner's fields are latched and replayed to the
// cache until granted, and the load response is routed back to the owner.
// Build option: define DCACHE_ARB_ROUND_ROBIN_EN for round-robin selection;
// otherwise fixed priority (port 0 > 1 > 2).
module dcache_req_arbiter #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 34,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            port_req_i,
  input  logic [NUM_PORTS-1:0]            port_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
  input  logic [NUM_PORTS*2-1:0]          port_size_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   port_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata_i,
  input  logic [NUM_PORTS-1:0]            port_kill_i,
  output logic [NUM_PORTS-1:0]            port_gnt_o,
  output logic [NUM_PORTS-1:0]            port_rvalid_o,
  output logic [DATA_WIDTH-1:0]           port_rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [1:0]                      mem_size_o,
  output logic [BE_WIDTH-1:0]             mem_be_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  output logic                            mem_kill_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT_RVALID
  } arb_state_e;

  arb_state_e               state_q;
  logic [IDX_W-1:0]         owner_q;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [1:0]               size_q;
  logic [BE_WIDTH-1:0]      be_q;
  logic [DATA_WIDTH-1:0]    wdata_q;

  logic [IDX_W-1:0]         winner;
  logic                     gnt_fire;
  logic                     rvalid_fire;

  // Per-port views of the packed request fields
  logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_PORTS];
  logic [1:0]               size_arr  [NUM_PORTS];
  logic [BE_WIDTH-1:0]      be_arr    [NUM_PORTS];
  logic [DATA_WIDTH-1:0]    wdata_arr [NUM_PORTS];

  // gnt/rvalid from the cache only count in the state that expects them
  assign gnt_fire    = (state_q == ARB_REQ) && mem_gnt_i;
  assign rvalid_fire = (state_q == ARB_WAIT_RVALID) && mem_rvalid_i;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign addr_arr[gi]      = port_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_arr[gi]      = port_size_i[gi*2 +: 2];
    assign be_arr[gi]        = port_be_i[gi*BE_WIDTH +: BE_WIDTH];
    assign wdata_arr[gi]     = port_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign port_gnt_o[gi]    = gnt_fire && (owner_q == IDX_W'(gi));
    assign port_rvalid_o[gi] = rvalid_fire && (owner_q == IDX_W'(gi));
  end

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]         rr_q;
  logic [2*NUM_PORTS-1:0]   req_rot;
  logic [IDX_W:0]           rr_sum;

  // Rotate requests so bit 0 is the port at rr_q, take the lowest set bit,
  // then map the rotated position back to a port index
  always_comb begin
    req_rot = {port_req_i, port_req_i} >> rr_q;
    rr_sum  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_rot[i]) rr_sum = {1'b0, rr_q} + (IDX_W+1)'(i);
    end
    if (rr_sum >= (IDX_W+1)'(NUM_PORTS)) rr_sum = rr_sum - (IDX_W+1)'(NUM_PORTS);
    winner = rr_sum[IDX_W-1:0];
  end

  // The port after the one just granted becomes the highest priority
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (gnt_fire) begin
      rr_q <= (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
    end
  end
`else
  // Fixed priority: the lowest-numbered requesting port wins
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_req_i[i]) winner = IDX_W'(i);
    end
  end
`endif

  // Arbitration FSM and holding registers for the winning request
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (|port_req_i) begin
            owner_q <= winner;
            we_q    <= port_we_i[winner];
            addr_q  <= addr_arr[winner];
            size_q  <= size_arr[winner];
            be_q    <= be_arr[winner];
            wdata_q <= wdata_arr[winner];
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_gnt_i) state_q <= we_q ? ARB_IDLE : ARB_WAIT_RVALID;
        end
        ARB_WAIT_RVALID: begin
          if (mem_rvalid_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req_o    = (state_q == ARB_REQ);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_size_o   = size_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_kill_o   = (state_q != ARB_IDLE) && port_kill_i[owner_q];
  assign port_rdata_o = rvalid_fire ? mem_rdata_i : '0;

  // A grant or response from the cache when none is expected is a protocol error
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_gnt_i |-> (state_q == ARB_REQ));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> (state_q == ARB_WAIT_RVALID));

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Testbench for dcache_req_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_dcache_req_arbiter;
  localparam int NP = 3;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     port_req_i, port_we_i, port_kill_i;
  logic [NP*AW-1:0]  port_addr_i;
  logic [NP*2-1:0]   port_size_i;
  logic [NP*BW-1:0]  port_be_i;
  logic [NP*DW-1:0]  port_wdata_i;
  logic [NP-1:0]     port_gnt_o, port_rvalid_o;
  logic [DW-1:0]     port_rdata_o;
  logic              mem_req_o, mem_we_o, mem_kill_o;
  logic [AW-1:0]     mem_addr_o;
  logic [1:0]        mem_size_o;
  logic [BW-1:0]     mem_be_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0]     mem_rdata_i;

  logic [AW-1:0]     r_addr  [NP];
  logic [1:0]        r_size  [NP];
  logic [BW-1:0]     r_be    [NP];
  logic [DW-1:0]     r_wdata [NP];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending transaction record
  bit            m_busy, m_granted;
  int            m_owner, m_rr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_size;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata;
  logic [NP-1:0] last_eg;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      port_addr_i[p*AW +: AW]  = r_addr[p];
      port_size_i[p*2 +: 2]    = r_size[p];
      port_be_i[p*BW +: BW]    = r_be[p];
      port_wdata_i[p*DW +: DW] = r_wdata[p];
    end
  end

  dcache_req_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .port_req_i(port_req_i), .port_we_i(port_we_i), .port_addr_i(port_addr_i),
    .port_size_i(port_size_i), .port_be_i(port_be_i), .port_wdata_i(port_wdata_i),
    .port_kill_i(port_kill_i), .port_gnt_o(port_gnt_o), .port_rvalid_o(port_rvalid_o),
    .port_rdata_o(port_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_size_o(mem_size_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_kill_o(mem_kill_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model predicts for this cycle
  task automatic check_model();
    logic [NP-1:0] eg, ev;
    logic [DW-1:0] ed;
    logic          ek;
    eg = '0; ev = '0; ed = '0; ek = 1'b0;
    if (m_busy && !m_granted && mem_gnt_i) eg[m_owner] = 1'b1;
    if (m_busy && m_granted && mem_rvalid_i) begin
      ev[m_owner] = 1'b1;
      ed = mem_rdata_i;
    end
    if (m_busy) ek = port_kill_i[m_owner];
    chk("m_mem_req", 64'(mem_req_o), 64'(m_busy && !m_granted));
    chk("m_port_gnt", 64'(port_gnt_o), 64'(eg));
    chk("m_port_rvalid", 64'(port_rvalid_o), 64'(ev));
    chk("m_port_rdata", 64'(port_rdata_o), 64'(ed));
    chk("m_mem_kill", 64'(mem_kill_o), 64'(ek));
    chk("m_mem_we", 64'(mem_we_o), 64'(m_we));
    chk("m_mem_addr", 64'(mem_addr_o), 64'(m_addr));
    chk("m_mem_size", 64'(mem_size_o), 64'(m_size));
    chk("m_mem_be", 64'(mem_be_o), 64'(m_be));
    chk("m_mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
    last_eg = eg;
  endtask

  // Advance the model across one clock edge using the current inputs
  task automatic model_edge();
    int w;
    if (!rst_ni) begin
      m_busy = 0; m_granted = 0; m_owner = 0; m_rr = 0;
      m_we = 0; m_addr = '0; m_size = '0; m_be = '0; m_wdata = '0;
    end else if (!m_busy) begin
      w = -1;
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NP; k++)
        if (w < 0 && port_req_i[(m_rr + k) % NP]) w = (m_rr + k) % NP;
`else
      for (int k = 0; k < NP; k++)
        if (w < 0 && port_req_i[k]) w = k;
`endif
      if (w >= 0) begin
        m_busy = 1; m_granted = 0; m_owner = w;
        m_we = port_we_i[w]; m_addr = r_addr[w]; m_size = r_size[w];
        m_be = r_be[w]; m_wdata = r_wdata[w];
      end
    end else if (!m_granted) begin
      if (mem_gnt_i) begin
        m_rr = (m_owner + 1) % NP;
        if (m_we) m_busy = 0;
        else m_granted = 1;
      end
    end else if (mem_rvalid_i) begin
      m_busy = 0;
    end
  endtask

  task automatic cyc();
    check_model();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int order [6];
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 0, 1, 2};
`else
    order = '{0, 0, 0, 0, 0, 0};
`endif
    rst_ni = 1'b0;
    port_req_i = '0; port_we_i = '0; port_kill_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int p = 0; p < NP; p++) begin
      r_addr[p] = '0; r_size[p] = '0; r_be[p] = '0; r_wdata[p] = '0;
    end
    @(posedge clk_i);
    model_edge();
    #1;
    // Reset state
    #1;
    chk("rst_mem_req", 64'(mem_req_o), 64'(0));
    chk("rst_port_gnt", 64'(port_gnt_o), 64'(0));
    chk("rst_port_rvalid", 64'(port_rvalid_o), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    cyc();
    rst_ni = 1'b1;

    // Single load on port 1
    port_req_i[1] = 1'b1; port_we_i[1] = 1'b0;
    r_addr[1] = 34'h0_8000_0010; r_size[1] = 2'b10;
    #1; chk("t1_c0_mem_req", 64'(mem_req_o), 64'(0)); cyc();
    mem_gnt_i = 1'b1;
    #1;
    chk("t1_c1_mem_req", 64'(mem_req_o), 64'(1));
    chk("t1_c1_gnt", 64'(port_gnt_o), 64'(3'b010));
    chk("t1_c1_addr", 64'(mem_addr_o), 64'(34'h0_8000_0010));
    chk("t1_c1_size", 64'(mem_size_o), 64'(2'b10));
    cyc();
    port_req_i[1] = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_c2_rvalid", 64'(port_rvalid_o), 64'(3'b010));
    chk("t1_c2_rdata", 64'(port_rdata_o), 64'(32'hDEAD_BEEF));
    chk("t1_c2_mem_req", 64'(mem_req_o), 64'(0));
    cyc();
    mem_rvalid_i = 1'b0;
    #1; chk("t1_c3_rdata_zero", 64'(port_rdata_o), 64'(0)); cyc();

    // Store on port 2 with the grant delayed three cycles
    port_req_i[2] = 1'b1; port_we_i[2] = 1'b1; r_addr[2] = 34'h1_0000_0100;
    r_size[2] = 2'b01; r_be[2] = 4'b0011; r_wdata[2] = 32'h1234_5678;
    #1; cyc();
    for (int k = 0; k < 4; k++) begin
      mem_gnt_i = (k == 3);
      #1;
      chk("t2_mem_req", 64'(mem_req_o), 64'(1));
      chk("t2_mem_we", 64'(mem_we_o), 64'(1));
      chk("t2_mem_be", 64'(mem_be_o), 64'(4'b0011));
      chk("t2_mem_wdata", 64'(mem_wdata_o), 64'(32'h1234_5678));
      chk("t2_gnt", 64'(port_gnt_o), (k == 3) ? 64'(3'b100) : 64'(0));
      chk("t2_rvalid", 64'(port_rvalid_o), 64'(0));
      cyc();
    end
    port_req_i[2] = 1'b0; mem_gnt_i = 1'b0;
    #1;
    chk("t2_after_gnt", 64'(port_gnt_o), 64'(0));
    chk("t2_after_req", 64'(mem_req_o), 64'(0));
    cyc();

    // All three ports requesting stores continuously
    for (int p = 0; p < NP; p++) begin
      port_req_i[p] = 1'b1; port_we_i[p] = 1'b1;
      r_addr[p] = AW'(34'h200 + p * 16); r_wdata[p] = DW'(32'hA000_0000 + p);
    end
    for (int g = 0; g < 6; g++) begin
      mem_gnt_i = 1'b0; #1; cyc();
      mem_gnt_i = 1'b1; #1;
      chk("t3_order", 64'(port_gnt_o), 64'(1) << order[g]);
      cyc();
    end
    port_req_i = '0; mem_gnt_i = 1'b0; #1; cyc();

    // Killed load still receives its response
    port_req_i[1] = 1'b1; port_we_i[1] = 1'b0; r_addr[1] = 34'h0_0000_0440;
    #1; cyc();
    mem_gnt_i = 1'b1; #1; cyc();
    port_req_i[1] = 1'b0; mem_gnt_i = 1'b0; port_kill_i[1] = 1'b1;
    #1;
    chk("t4_kill", 64'(mem_kill_o), 64'(1));
    chk("t4_no_rvalid", 64'(port_rvalid_o), 64'(0));
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
    #1;
    chk("t4_rvalid", 64'(port_rvalid_o), 64'(3'b010));
    chk("t4_rdata", 64'(port_rdata_o), 64'(32'hCAFE_0001));
    cyc();
    mem_rvalid_i = 1'b0;
    #1; chk("t4_idle_kill", 64'(mem_kill_o), 64'(0)); cyc();
    port_kill_i[1] = 1'b0;

    // Reset while waiting for a load response
    port_req_i[0] = 1'b1; port_we_i[0] = 1'b0; r_addr[0] = 34'h3_0000_0008;
    #1; cyc();
    mem_gnt_i = 1'b1; #1; cyc();
    port_req_i[0] = 1'b0; mem_gnt_i = 1'b0; rst_ni = 1'b0;
    #1; cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA; port_kill_i[0] = 1'b1;
    #1;
    chk("t5_rvalid", 64'(port_rvalid_o), 64'(0));
    chk("t5_rdata", 64'(port_rdata_o), 64'(0));
    chk("t5_mem_req", 64'(mem_req_o), 64'(0));
    chk("t5_mem_addr", 64'(mem_addr_o), 64'(0));
    chk("t5_kill", 64'(mem_kill_o), 64'(0));
    cyc();
    rst_ni = 1'b1; mem_rvalid_i = 1'b0; port_kill_i[0] = 1'b0;
    #1; cyc();

    // Port 0 requests in the cycle port 1's response returns
    port_req_i[1] = 1'b1; port_we_i[1] = 1'b0; r_addr[1] = 34'h0_0000_0880;
    #1; cyc();
    mem_gnt_i = 1'b1; #1; cyc();
    port_req_i[1] = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h0BAD_F00D;
    port_req_i[0] = 1'b1; port_we_i[0] = 1'b1; r_addr[0] = 34'h0_0000_0123;
    #1; chk("t6_rvalid", 64'(port_rvalid_o), 64'(3'b010)); cyc();
    mem_rvalid_i = 1'b0;
    #1; chk("t6_select_cycle", 64'(mem_req_o), 64'(0)); cyc();
    mem_gnt_i = 1'b1;
    #1;
    chk("t6_mem_req", 64'(mem_req_o), 64'(1));
    chk("t6_mem_addr", 64'(mem_addr_o), 64'(34'h0_0000_0123));
    chk("t6_gnt", 64'(port_gnt_o), 64'(3'b001));
    cyc();
    port_req_i[0] = 1'b0; mem_gnt_i = 1'b0;
    #1; cyc();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (last_eg[p]) port_req_i[p] = 1'b0;
        if (!port_req_i[p] && $urandom_range(0, 3) == 0) begin
          port_req_i[p] = 1'b1;
          port_we_i[p]  = 1'($urandom_range(0, 1));
          r_addr[p]     = AW'({$urandom, $urandom});
          r_size[p]     = 2'($urandom_range(0, 3));
          r_be[p]       = BW'($urandom);
          r_wdata[p]    = DW'($urandom);
        end
        port_kill_i[p] = ($urandom_range(0, 7) == 0);
      end
      mem_gnt_i    = (m_busy && !m_granted) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rvalid_i = (m_busy && m_granted) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata_i  = DW'($urandom);
      #1;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
